// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx_sched packet scheduler.
package uart_pkg;

    localparam int         BYTE_CNT_W = 8;
    localparam logic [7:0] HDR_BASE   = 8'h80;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t S_IDLE    = 3'd0;
    localparam sched_state_t S_HDR     = 3'd1;
    localparam sched_state_t S_LOAD    = 3'd2;
    localparam sched_state_t S_ISSUE   = 3'd3;
    localparam sched_state_t S_WAIT_HI = 3'd4;
    localparam sched_state_t S_WAIT_LO = 3'd5;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr wins.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] pos;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_sched.sv
// Packet-granular round-robin scheduler feeding one shared uart_tx.
// Optional per-grant header byte (0x80 | requester index) under UART_TX_SCHED_HDR_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   pkt_done,
    output logic                   pkt_trunc
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  trunc_q, trunc_d;
    logic                  release_pkt;
`ifdef UART_TX_SCHED_HDR_EN
    logic                  hdr_q, hdr_d;
`endif

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IW-1:0]         arb_idx;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        byte_cnt_d  = byte_cnt_q;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        done_d      = 1'b0;
        trunc_d     = 1'b0;
        release_pkt = 1'b0;
        req_ready   = '0;
`ifdef UART_TX_SCHED_HDR_EN
        hdr_d       = hdr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d    = arb_gnt;
                    idx_d      = arb_idx;
                    byte_cnt_d = '0;
`ifdef UART_TX_SCHED_HDR_EN
                    state_d    = S_HDR;
`else
                    state_d    = S_LOAD;
`endif
                end
            end
`ifdef UART_TX_SCHED_HDR_EN
            S_HDR: begin
                tx_data_d = HDR_BASE | 8'(idx_q);
                hdr_d     = 1'b1;
                state_d   = S_ISSUE;
            end
`endif
            S_LOAD: begin
                // grant_q is one-hot, so the accept strobe can never have more than one bit.
                if (|(grant_q & req_valid)) begin
                    req_ready  = grant_q;
                    tx_data_d  = req_data[{idx_q, 3'b000} +: 8];
                    last_d     = req_last[idx_q];
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (tx_busy) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
`ifdef UART_TX_SCHED_HDR_EN
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = S_LOAD;
                    end else
`endif
                    if (last_q) begin
                        done_d      = 1'b1;
                        release_pkt = 1'b1;
                    end else if (byte_cnt_q == BYTE_CNT_W'(MAX_PKT_LEN)) begin
                        trunc_d     = 1'b1;
                        release_pkt = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (release_pkt) begin
            grant_d = '0;
            ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            state_d = S_IDLE;
        end
    end

    // NOTE: reset is synchronous here: resetn is only looked at on the clock edge.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            tx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            trunc_q    <= 1'b0;
`ifdef UART_TX_SCHED_HDR_EN
            hdr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            done_q     <= done_d;
            trunc_q    <= trunc_d;
`ifdef UART_TX_SCHED_HDR_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    assign tx_en     = (state_q == S_ISSUE);
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign pkt_done  = done_q;
    assign pkt_trunc = trunc_q;

endmodule : uart_tx_sched

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a 10-cycle-busy transmitter model.
// Header expectations follow UART_TX_SCHED_HDR_EN when it is defined.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int N    = 4;
    localparam int MAXL = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_en;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic [N-1:0]     grant;
    logic             pkt_done;
    logic             pkt_trunc;

    uart_tx_sched #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .pkt_done  (pkt_done),
        .pkt_trunc (pkt_trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]   data;
        logic [N-1:0] gnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] rq[N][$];
    logic [N-1:0] hold;

    int n_cmp = 0, n_err = 0;
    int n_done = 0, n_trunc = 0, n_txen = 0, n_ready = 0;

    // Transmitter model: busy for 10 cycles after each start strobe.
    int busy_cnt;
    always @(posedge clk) begin
        if (!resetn)         busy_cnt <= 0;
        else if (tx_en)      busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Requester models present the queue head mid-cycle and pop it on accept.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0 && !hold[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (resetn && req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    end

    // Output monitor: every tx_en is scored against the expected queue.
    always @(negedge clk) begin
        if (resetn) begin
            if (tx_en) begin
                exp_t e;
                n_txen++;
                n_cmp++;
                if (tx_busy) begin
                    n_err++;
                    $display("FAIL busy_rule: tx_en=1 while tx_busy=%b", tx_busy);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_byte: unexpected byte %02h grant=%b, want none", tx_data, grant);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e.data || grant !== e.gnt) begin
                        n_err++;
                        $display("FAIL tx_byte: got data=%02h grant=%b, want data=%02h grant=%b",
                                 tx_data, grant, e.data, e.gnt);
                    end
                end
            end
            if (|req_ready) begin
                n_ready++;
                n_cmp++;
                if ($countones(req_ready) != 1) begin
                    n_err++;
                    $display("FAIL ready_onehot: req_ready=%b, want one bit", req_ready);
                end
            end
            if (pkt_done)  n_done++;
            if (pkt_trunc) n_trunc++;
        end
    end

    task automatic put_req(input int r, input logic [7:0] d, input logic last);
        rq[r].push_back({last, d});
    endtask

    task automatic expect_byte(input int r, input logic [7:0] d);
        exp_q.push_back({d, N'(1 << r)});
    endtask

    task automatic expect_grant(input int r);
`ifdef UART_TX_SCHED_HDR_EN
        exp_q.push_back({8'h80 | 8'(r), N'(1 << r)});
`else
        if (r < 0) $display("unreachable");
`endif
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while (!(exp_q.size() == 0 && grant == '0 && rq_empty()) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc >= 3000) begin
            n_err++;
            $display("FAIL %s_timeout: %0d bytes still expected, want 0", tag, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== '0 || tx_en !== 1'b0 || grant !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: ready=%b tx_en=%b grant=%b, want 0/0/0", req_ready, tx_en, grant);
        end
        n_cmp++;
        if (tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: tx_data=%02h, want 00", tx_data);
        end
        n_cmp++;
        if (pkt_done !== 1'b0 || pkt_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulses: done=%b trunc=%b, want 0/0", pkt_done, pkt_trunc);
        end
        n_cmp++;
        if (dut.ptr_q !== 2'd0 || dut.state_q !== S_IDLE) begin
            n_err++;
            $display("FAIL reset_state: ptr=%0d state=%0d, want 0/IDLE", dut.ptr_q, dut.state_q);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_packet;
        int tx0 = n_txen, d0 = n_done, t0 = n_trunc;
        expect_grant(1);
        put_req(1, 8'h11, 1'b0); expect_byte(1, 8'h11);
        put_req(1, 8'h22, 1'b0); expect_byte(1, 8'h22);
        put_req(1, 8'h33, 1'b1); expect_byte(1, 8'h33);
        wait_drain("single");
        n_cmp++;
`ifdef UART_TX_SCHED_HDR_EN
        if (n_txen - tx0 != 4) begin
`else
        if (n_txen - tx0 != 3) begin
`endif
            n_err++;
            $display("FAIL single_txen_count: got %0d starts", n_txen - tx0);
        end
        n_cmp++;
        if (n_done - d0 != 1 || n_trunc - t0 != 0) begin
            n_err++;
            $display("FAIL single_pulses: done=%0d trunc=%0d, want 1/0", n_done - d0, n_trunc - t0);
        end
        n_cmp++;
        if (dut.ptr_q !== 2'd2) begin
            n_err++;
            $display("FAIL single_ptr: ptr=%0d, want 2", dut.ptr_q);
        end
    endtask

    task automatic test_fairness;
        int d0;
        resetn = 1'b0;
        for (int r = 0; r < N; r++) begin
            put_req(r, 8'(16 * r + 1), 1'b0);
            put_req(r, 8'(16 * r + 2), 1'b1);
        end
        put_req(0, 8'h03, 1'b0);
        put_req(0, 8'h04, 1'b1);
        for (int r = 0; r < N; r++) begin
            expect_grant(r);
            expect_byte(r, 8'(16 * r + 1));
            expect_byte(r, 8'(16 * r + 2));
        end
        expect_grant(0);
        expect_byte(0, 8'h03);
        expect_byte(0, 8'h04);
        repeat (3) @(negedge clk);
        d0 = n_done;
        resetn = 1'b1;
        wait_drain("fair");
        n_cmp++;
        if (n_done - d0 != 5) begin
            n_err++;
            $display("FAIL fair_done: got %0d packets, want 5", n_done - d0);
        end
        n_cmp++;
        if (dut.ptr_q !== 2'd1) begin
            n_err++;
            $display("FAIL fair_ptr: ptr=%0d, want 1", dut.ptr_q);
        end
    endtask

    task automatic test_truncation;
        int d0 = n_done, t0 = n_trunc;
        for (int k = 0; k < 6; k++) put_req(2, 8'(8'hA0 + k), (k == 5));
        put_req(3, 8'hB0, 1'b1);
        expect_grant(2);
        for (int k = 0; k < 4; k++) expect_byte(2, 8'(8'hA0 + k));
        expect_grant(3);
        expect_byte(3, 8'hB0);
        expect_grant(2);
        expect_byte(2, 8'hA4);
        expect_byte(2, 8'hA5);
        wait_drain("trunc");
        n_cmp++;
        if (n_trunc - t0 != 1) begin
            n_err++;
            $display("FAIL trunc_pulse: got %0d, want 1", n_trunc - t0);
        end
        n_cmp++;
        if (n_done - d0 != 2) begin
            n_err++;
            $display("FAIL trunc_done: got %0d, want 2", n_done - d0);
        end
    endtask

    task automatic test_stall;
        int cyc = 0;
        put_req(0, 8'hC1, 1'b0);
        put_req(0, 8'hC2, 1'b0);
        put_req(0, 8'hC3, 1'b1);
        expect_grant(0);
        expect_byte(0, 8'hC1);
        expect_byte(0, 8'hC2);
        expect_byte(0, 8'hC3);
        while (!req_ready[0] && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        hold[0] = 1'b1;
        n_cmp++;
        if (cyc >= 200) begin
            n_err++;
            $display("FAIL stall_accept_timeout: no accept from req0");
        end
        repeat (20) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut.state_q !== S_LOAD || grant !== 4'b0001 || tx_en !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: state=%0d grant=%b tx_en=%b, want LOAD/0001/0",
                         dut.state_q, grant, tx_en);
            end
        end
        @(posedge clk);
        #1 hold[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (tx_en !== 1'b1 || tx_data !== 8'hC2) begin
            n_err++;
            $display("FAIL stall_resume: tx_en=%b data=%02h, want 1/C2", tx_en, tx_data);
        end
        wait_drain("stall");
    endtask

    task automatic test_reset_mid;
        int cyc = 0;
        int d0;
        put_req(1, 8'hD1, 1'b0);
        put_req(1, 8'hD2, 1'b1);
        expect_grant(1);
        expect_byte(1, 8'hD1);
        while (dut.state_q !== S_WAIT_LO && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc >= 200) begin
            n_err++;
            $display("FAIL rstmid_timeout: never reached WAIT_LO");
        end
        resetn = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if (grant !== '0 || tx_en !== 1'b0 || tx_data !== 8'h00 || req_ready !== '0 ||
            pkt_done !== 1'b0 || pkt_trunc !== 1'b0 || dut.ptr_q !== 2'd0) begin
            n_err++;
            $display("FAIL rstmid_outputs: grant=%b tx_en=%b data=%02h ready=%b done=%b trunc=%b ptr=%0d, want all 0",
                     grant, tx_en, tx_data, req_ready, pkt_done, pkt_trunc, dut.ptr_q);
        end
        resetn = 1'b1;
        @(negedge clk);
        d0 = n_done;
        put_req(2, 8'hE1, 1'b0);
        put_req(2, 8'hE2, 1'b1);
        expect_grant(2);
        expect_byte(2, 8'hE1);
        expect_byte(2, 8'hE2);
        wait_drain("rstmid");
        n_cmp++;
        if (n_done - d0 != 1) begin
            n_err++;
            $display("FAIL rstmid_done: got %0d, want 1", n_done - d0);
        end
    endtask

    task automatic test_header;
        int r0 = n_ready, tx0 = n_txen;
        put_req(3, 8'h5A, 1'b1);
        expect_grant(3);
        expect_byte(3, 8'h5A);
        wait_drain("hdr");
        n_cmp++;
        if (n_ready - r0 != 1) begin
            n_err++;
            $display("FAIL hdr_ready_count: got %0d, want 1", n_ready - r0);
        end
        n_cmp++;
`ifdef UART_TX_SCHED_HDR_EN
        if (n_txen - tx0 != 2) begin
`else
        if (n_txen - tx0 != 1) begin
`endif
            n_err++;
            $display("FAIL hdr_txen_count: got %0d starts", n_txen - tx0);
        end
    endtask

    initial begin
        hold      = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_single_packet();
        test_fairness();
        test_truncation();
        test_stall();
        test_reset_mid();
        test_header();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_sched
